uart_ctrl_seq: RTL and testbench

UART_CTRL_SEQ -- requirements
Module: uart_ctrl_seq

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_rr_arb2.sv | 37 +++
 rtl/uart_ctrl_seq.sv | 212 +++++++++++++++++++++
 tb/tb_uart_ctrl_seq.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART control sequencer: register map, status bit positions
// and the sequencer state encoding.
package uart_pkg;

    localparam logic [2:0] ADDR_CONTROL  = 3'h0;
    localparam logic [2:0] ADDR_BAUD_GEN = 3'h1;
    localparam logic [2:0] ADDR_TX_FIFO  = 3'h4;
    localparam logic [2:0] ADDR_RX_FIFO  = 3'h5;

    localparam int unsigned STAT_RX_EMPTY = 0;
    localparam int unsigned STAT_RX_FULL  = 1;
    localparam int unsigned STAT_TX_EMPTY = 2;
    localparam int unsigned STAT_TX_FULL  = 3;

    localparam logic [3:0] BE_ALL   = 4'hF;
    localparam logic [3:0] BE_BYTE0 = 4'h1;
    localparam logic [3:0] BE_BYTE1 = 4'h2;

    typedef enum logic [2:0] {
        StWrBaud,
        StWrCtrl,
        StRdStat,
        StRdRx,
        StWrTx
    } state_e;

    function automatic logic [31:0] tx_word(logic [7:0] data);
        return {24'h0, data};
    endfunction

endpackage

// File: rtl/uart_rr_arb2.sv
// Two-way round-robin arbiter; on a tie the requester not granted last wins.
module uart_rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] gnt_o
);

    // ptr_q = 0 favours requester 0, ptr_q = 1 favours requester 1
    logic ptr_q;
    logic ptr_d;

    always_comb begin
        if (req_i == 2'b11) begin
            gnt_o = ptr_q ? 2'b10 : 2'b01;
        end else begin
            gnt_o = req_i;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept_i && (gnt_o != 2'b00)) begin
            ptr_d = gnt_o[0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/uart_ctrl_seq.sv
// Avalon-MM master sequencer for a UART core: programs baud and control, then polls status
// and moves bytes from the RX FIFO to a sink and from two arbitrated requesters to the TX FIFO.
module uart_ctrl_seq
    import uart_pkg::*;
#(
    parameter logic [11:0] BAUD_FREQ  = 12'h001,
    parameter logic [15:0] BAUD_LIMIT = 16'h01B2,
    parameter logic [3:0]  CTRL_CFG   = 4'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic [2:0]  avm_address_o,
    output logic        avm_write_o,
    output logic        avm_read_o,
    output logic [31:0] avm_writedata_o,
    output logic [3:0]  avm_byteenable_o,
    input  logic        avm_waitrequest_i,
    input  logic [31:0] avm_readdata_i,
    input  logic        s0_valid,
    input  logic [7:0]  s0_data,
    output logic        s0_ready,
    input  logic        s1_valid,
    input  logic [7:0]  s1_data,
    output logic        s1_ready,
    output logic        rx_valid,
    output logic [7:0]  rx_data,
    output logic        rx_err,
    input  logic        rx_ready,
    output logic        init_done
);

    state_e      state_q, state_d;
    logic        read_q, read_d;
    logic        write_q, write_d;
    logic [2:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        init_done_q, init_done_d;
    logic [3:0]  stat_q, stat_d;
    logic        stat_vld_q, stat_vld_d;
    logic        gnt_sel_q, gnt_sel_d;
    logic        rx_valid_q, rx_valid_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_err_q, rx_err_d;

    logic        busy;
    logic        done;
    logic        arb_accept;
    logic [1:0]  arb_gnt;
    logic        unused_bits;

    assign busy = read_q | write_q;
    assign done = busy & ~avm_waitrequest_i;

    // Only the status nibble's empty/full flags that gate traffic are consulted.
    assign unused_bits = ^{avm_readdata_i[31:9], stat_q[STAT_RX_FULL], stat_q[STAT_TX_EMPTY]};

    uart_rr_arb2 u_arb (
        .clk      (clk),
        .reset    (reset),
        .req_i    ({s1_valid, s0_valid}),
        .accept_i (arb_accept),
        .gnt_o    (arb_gnt)
    );

    always_comb begin
        state_d     = state_q;
        read_d      = read_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        init_done_d = init_done_q;
        stat_d      = stat_q;
        stat_vld_d  = stat_vld_q;
        gnt_sel_d   = gnt_sel_q;
        rx_valid_d  = rx_valid_q & ~rx_ready;
        rx_data_d   = rx_data_q;
        rx_err_d    = rx_err_q;
        arb_accept  = 1'b0;

        unique case (state_q)
            StWrBaud: begin
                if (!busy) begin
                    write_d = 1'b1;
                    addr_d  = ADDR_BAUD_GEN;
                    wdata_d = {4'h0, BAUD_FREQ, BAUD_LIMIT};
                    be_d    = BE_ALL;
                end else if (done) begin
                    write_d = 1'b0;
                    state_d = StWrCtrl;
                end
            end
            StWrCtrl: begin
                if (!busy) begin
                    write_d = 1'b1;
                    addr_d  = ADDR_CONTROL;
                    wdata_d = {20'h0, CTRL_CFG, 8'h0};
                    be_d    = BE_BYTE1;
                end else if (done) begin
                    write_d     = 1'b0;
                    init_done_d = 1'b1;
                    state_d     = StRdStat;
                end
            end
            StRdStat: begin
                if (busy) begin
                    if (done) begin
                        read_d     = 1'b0;
                        stat_d     = avm_readdata_i[3:0];
                        stat_vld_d = 1'b1;
                    end
                end else if (!stat_vld_q) begin
                    read_d  = 1'b1;
                    addr_d  = ADDR_CONTROL;
                    wdata_d = '0;
                    be_d    = BE_ALL;
                end else begin
                    // Idle cycle after the status read: decide, and issue the next transfer.
                    stat_vld_d = 1'b0;
                    if (!stat_q[STAT_RX_EMPTY] && !rx_valid_q) begin
                        state_d = StRdRx;
                        read_d  = 1'b1;
                        addr_d  = ADDR_RX_FIFO;
                        wdata_d = '0;
                        be_d    = BE_ALL;
                    end else if (!stat_q[STAT_TX_FULL] && (arb_gnt != 2'b00)) begin
                        state_d    = StWrTx;
                        write_d    = 1'b1;
                        addr_d     = ADDR_TX_FIFO;
                        wdata_d    = tx_word(arb_gnt[1] ? s1_data : s0_data);
                        be_d       = BE_BYTE0;
                        gnt_sel_d  = arb_gnt[1];
                        arb_accept = 1'b1;
                    end else begin
                        read_d  = 1'b1;
                        addr_d  = ADDR_CONTROL;
                        wdata_d = '0;
                        be_d    = BE_ALL;
                    end
                end
            end
            StRdRx: begin
                if (done) begin
                    read_d     = 1'b0;
                    rx_data_d  = avm_readdata_i[7:0];
                    rx_err_d   = avm_readdata_i[8];
                    rx_valid_d = 1'b1;
                    state_d    = StRdStat;
                end
            end
            StWrTx: begin
                if (done) begin
                    write_d = 1'b0;
                    state_d = StRdStat;
                end
            end
            default: begin
                state_d = StWrBaud;
                read_d  = 1'b0;
                write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StWrBaud;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            init_done_q <= 1'b0;
            stat_q      <= '0;
            stat_vld_q  <= 1'b0;
            gnt_sel_q   <= 1'b0;
            rx_valid_q  <= 1'b0;
            rx_data_q   <= '0;
            rx_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            read_q      <= read_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            init_done_q <= init_done_d;
            stat_q      <= stat_d;
            stat_vld_q  <= stat_vld_d;
            gnt_sel_q   <= gnt_sel_d;
            rx_valid_q  <= rx_valid_d;
            rx_data_q   <= rx_data_d;
            rx_err_q    <= rx_err_d;
        end
    end

    assign avm_address_o    = addr_q;
    assign avm_write_o      = write_q;
    assign avm_read_o       = read_q;
    assign avm_writedata_o  = wdata_q;
    assign avm_byteenable_o = be_q;
    assign init_done        = init_done_q;
    assign rx_valid         = rx_valid_q;
    assign rx_data          = rx_data_q;
    assign rx_err           = rx_err_q;

    // Ready marks the completing cycle of the granted TX write only.
    assign s0_ready = (state_q == StWrTx) & write_q & ~avm_waitrequest_i & ~gnt_sel_q;
    assign s1_ready = (state_q == StWrTx) & write_q & ~avm_waitrequest_i & gnt_sel_q;

endmodule

// File: tb/tb_uart_ctrl_seq.sv
// Scoreboard bench for uart_ctrl_seq: an Avalon slave model serves status/RX data and a
// transaction-level reference predicts every bus transfer, ready pulse and RX byte.
module tb_uart_ctrl_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  avm_address_o;
    logic        avm_write_o, avm_read_o;
    logic [31:0] avm_writedata_o;
    logic [3:0]  avm_byteenable_o;
    logic        avm_waitrequest_i;
    logic [31:0] avm_readdata_i;
    logic        s0_valid, s0_ready, s1_valid, s1_ready;
    logic [7:0]  s0_data, s1_data;
    logic        rx_valid, rx_err, rx_ready, init_done;
    logic [7:0]  rx_data;

    typedef struct packed {
        logic        wr;
        logic [2:0]  addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [1:0]  rdy;
    } xfer_t;

    typedef struct packed {
        logic [3:0] st;
        logic [8:0] p0;
        logic [8:0] p1;
        logic       acc;
    } step_t;

    xfer_t      exp_q[$];
    logic [8:0] rx_q[$];
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    step_t      script[$];

    int   checks = 0;
    int   errors = 0;
    int   n_done = 0;
    logic m_last, m_rx_pending, m_init;
    bit   hold_tx = 0, force_tx = 0, pop0 = 0, pop1 = 0, chosen = 0;

    uart_ctrl_seq dut (
        .clk               (clk),
        .reset             (reset),
        .avm_address_o     (avm_address_o),
        .avm_write_o       (avm_write_o),
        .avm_read_o        (avm_read_o),
        .avm_writedata_o   (avm_writedata_o),
        .avm_byteenable_o  (avm_byteenable_o),
        .avm_waitrequest_i (avm_waitrequest_i),
        .avm_readdata_i    (avm_readdata_i),
        .s0_valid          (s0_valid),
        .s0_data           (s0_data),
        .s0_ready          (s0_ready),
        .s1_valid          (s1_valid),
        .s1_data           (s1_data),
        .s1_ready          (s1_ready),
        .rx_valid          (rx_valid),
        .rx_data           (rx_data),
        .rx_err            (rx_err),
        .rx_ready          (rx_ready),
        .init_done         (init_done)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic xfer_t mk(logic wr, logic [2:0] a, logic [31:0] d, logic [3:0] be,
                                 logic [1:0] rdy);
        xfer_t x;
        x.wr = wr; x.addr = a; x.data = d; x.be = be; x.rdy = rdy;
        return x;
    endfunction

    function automatic step_t stp(logic [3:0] st, logic [8:0] p0, logic [8:0] p1, logic acc);
        step_t s;
        s.st = st; s.p0 = p0; s.p1 = p1; s.acc = acc;
        return s;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        rx_q.delete();
        exp_q.push_back(mk(1'b1, 3'h1, 32'h0001_01B2, 4'hF, 2'b00));
        exp_q.push_back(mk(1'b1, 3'h0, 32'h0000_0000, 4'h2, 2'b00));
        exp_q.push_back(mk(1'b0, 3'h0, 32'h0, 4'h0, 2'b00));
        m_last = 1'b1;
        m_rx_pending = 1'b0;
        m_init = 1'b0;
        pop0 = 0;
        pop1 = 0;
    endtask

    // Serve one status read and predict the transfer(s) that must follow it.
    task automatic serve_status();
        step_t s;
        logic [3:0] st;
        bit acc, g1;
        logic [7:0] b;
        if (force_tx) begin
            force_tx = 0;
            st = 4'h1;
            q0.push_back(8'h5A);
            acc = 0;
        end else if (script.size() > 0) begin
            s = script.pop_front();
            st = s.st;
            if (s.p0[8]) q0.push_back(s.p0[7:0]);
            if (s.p1[8]) q1.push_back(s.p1[7:0]);
            acc = s.acc;
        end else begin
            st[0] = ($urandom_range(0, 9) < 6);
            st[3] = ($urandom_range(0, 9) < 3);
            st[2:1] = 2'($urandom_range(0, 3));
            if (q0.size() < 3 && $urandom_range(0, 9) < 4) q0.push_back(8'($urandom));
            if (q1.size() < 3 && $urandom_range(0, 9) < 4) q1.push_back(8'($urandom));
            acc = ($urandom_range(0, 1) == 1);
        end
        if (acc && m_rx_pending) begin
            rx_ready = 1'b1;
            m_rx_pending = 1'b0;
        end
        avm_readdata_i = {28'($urandom), st};
        if (!st[0] && !m_rx_pending) begin
            exp_q.push_back(mk(1'b0, 3'h5, 32'h0, 4'h0, 2'b00));
            m_rx_pending = 1'b1;
        end else if (!st[3] && (q0.size() > 0 || q1.size() > 0)) begin
            g1 = (q0.size() > 0 && q1.size() > 0) ? (m_last == 1'b0) : (q1.size() > 0);
            b = g1 ? q1[0] : q0[0];
            exp_q.push_back(mk(1'b1, 3'h4, {24'h0, b}, 4'h1, g1 ? 2'b10 : 2'b01));
            m_last = g1;
        end
        exp_q.push_back(mk(1'b0, 3'h0, 32'h0, 4'h0, 2'b00));
    endtask

    // Slave and source/sink driver: acts 1 time unit after each rising edge.
    initial begin : drv
        logic [31:0] w;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                chosen = 0;
                continue;
            end
            if (pop0 && q0.size() > 0) void'(q0.pop_front());
            if (pop1 && q1.size() > 0) void'(q1.pop_front());
            pop0 = 0;
            pop1 = 0;
            if (rx_ready) rx_ready = 1'b0;
            if (!avm_read_o) begin
                chosen = 0;
            end else if (!chosen) begin
                chosen = 1;
                if (avm_address_o == 3'h0) begin
                    serve_status();
                end else if (avm_address_o == 3'h5) begin
                    w = (script.size() > 0) ? 32'h0000_013C : $urandom;
                    avm_readdata_i = w;
                    rx_q.push_back(w[8:0]);
                end else begin
                    avm_readdata_i = $urandom;
                end
            end
            avm_waitrequest_i = (hold_tx && avm_write_o && avm_address_o == 3'h4) ? 1'b1 :
                                ($urandom_range(0, 3) == 0);
            s0_valid = (q0.size() > 0);
            s0_data  = (q0.size() > 0) ? q0[0] : 8'h00;
            s1_valid = (q1.size() > 0);
            s1_data  = (q1.size() > 0) ? q1[0] : 8'h00;
        end
    end

    // Monitor: samples on the falling edge and pops the scoreboard on each completion.
    initial begin : mon
        xfer_t e;
        logic [40:0] snap;
        bit held, gap;
        int idle;
        held = 0; gap = 0; idle = 0; snap = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                held = 0; gap = 0; idle = 0;
                continue;
            end
            check("init_done", init_done, m_init);
            if (gap) begin
                check("stat_read_gap", {avm_read_o, avm_write_o}, 2'b00);
                gap = 0;
            end
            if (held) begin
                check("bus_stable", {avm_read_o, avm_write_o, avm_address_o, avm_writedata_o,
                                     avm_byteenable_o}, snap);
                held = 0;
            end
            if ((avm_read_o || avm_write_o) && avm_waitrequest_i) begin
                held = 1;
                snap = {avm_read_o, avm_write_o, avm_address_o, avm_writedata_o,
                        avm_byteenable_o};
            end
            if ((avm_read_o || avm_write_o) && !avm_waitrequest_i) begin
                n_done++;
                idle = 0;
                if (exp_q.size() == 0) begin
                    check("xfer_unexpected", {avm_write_o, avm_address_o}, 64'hFFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("xfer_kind", {avm_read_o, avm_write_o, avm_address_o},
                          {~e.wr, e.wr, e.addr});
                    if (e.wr) check("xfer_data", {avm_writedata_o, avm_byteenable_o},
                                    {e.data, e.be});
                    check("tx_ready", {s1_ready, s0_ready}, e.rdy);
                    if (e.wr && e.addr == 3'h0) m_init = 1'b1;
                    if (!e.wr && e.addr == 3'h0) gap = 1;
                end
                if (s0_ready) pop0 = 1;
                if (s1_ready) pop1 = 1;
            end else begin
                check("ready_idle", {s1_ready, s0_ready}, 2'b00);
                idle++;
                if (idle == 200) check("bus_stall", 1'b1, 1'b0);
            end
            if (rx_valid) begin
                if (rx_q.size() == 0) begin
                    check("rx_unexpected", rx_valid, 1'b0);
                end else begin
                    check("rx_word", {rx_err, rx_data}, rx_q[0]);
                    if (rx_ready) void'(rx_q.pop_front());
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_bus_ctl"}, {avm_read_o, avm_write_o, avm_address_o, avm_byteenable_o}, 0);
        check({tag, "_wdata"}, avm_writedata_o, 0);
        check({tag, "_ready"}, {s1_ready, s0_ready}, 0);
        check({tag, "_rx"}, {rx_valid, rx_err, rx_data}, 0);
        check({tag, "_init"}, init_done, 0);
    endtask

    initial begin : main
        bit seen;
        reset = 1'b1;
        avm_waitrequest_i = 1'b0;
        avm_readdata_i = '0;
        rx_ready = 1'b0;
        s0_valid = 1'b0; s0_data = '0;
        s1_valid = 1'b0; s1_data = '0;
        model_reset();
        script.push_back(stp(4'h1, 9'h111, 9'h122, 1'b0));
        script.push_back(stp(4'h1, 9'h111, 9'h000, 1'b0));
        script.push_back(stp(4'h1, 9'h000, 9'h122, 1'b0));
        script.push_back(stp(4'h1, 9'h000, 9'h000, 1'b0));
        script.push_back(stp(4'h1, 9'h1A5, 9'h000, 1'b0));
        script.push_back(stp(4'h0, 9'h000, 9'h000, 1'b0));
        script.push_back(stp(4'h0, 9'h000, 9'h000, 1'b0));
        script.push_back(stp(4'h0, 9'h000, 9'h000, 1'b0));
        script.push_back(stp(4'h0, 9'h000, 9'h000, 1'b1));
        script.push_back(stp(4'h8, 9'h000, 9'h177, 1'b0));
        script.push_back(stp(4'h8, 9'h000, 9'h000, 1'b0));
        script.push_back(stp(4'h1, 9'h000, 9'h000, 1'b1));

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("first_write", {avm_write_o, avm_address_o}, {1'b1, 3'h1});

        repeat (3000) @(posedge clk);

        // Hold a TX write in waitrequest and hit it with reset.
        hold_tx = 1;
        force_tx = 1;
        seen = 0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(posedge clk);
            #2;
            seen = avm_write_o && (avm_address_o == 3'h4);
        end
        check("tx_hold_seen", seen, 1'b1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        rx_ready = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("mid_tx_reset");
        hold_tx = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("restart_write", {avm_write_o, avm_address_o}, {1'b1, 3'h1});

        repeat (1500) @(posedge clk);
        check("progress", (n_done > 200), 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
